// File: rtl/banked_sram_buffer.sv
// rtl/banked_sram_buffer.sv - NUM_BANKS single-port RAM banks stitched into one linear word-address space
//
// Purpose: banked on-chip buffer between the controller RAM port and the compute
// datapath. Adds read-valid tracking, a sticky out-of-range flag, zero-fill on
// unmapped reads and sign/zero extension of the stored word to OUT_W.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   cs         access enable
//   oe         output enable, sampled in the read-data cycle
//   W_req      active-low write strobe (0 = write, 1 = read)
//   addr       word address: [BANK_AW+SEL_W-1:BANK_AW] bank, [BANK_AW-1:0] offset
//   W_data     write data, only [DATA_W-1:0] is stored
//   R_data     read data, extended per SIGN_EXT, 0 when not a valid in-range read
//   r_valid    R_data carries a read result
//   err_oor    sticky out-of-range access flag
//   err_clr    clears err_oor (a same-cycle out-of-range access wins)
//
// Optional build macro SRAM_OUTREG_EN: adds a registered output stage, making the
// read latency 2 cycles instead of 1.

module banked_sram_buffer #(
  parameter int DATA_W    = 16,
  parameter int BANK_AW   = 15,
  parameter int NUM_BANKS = 6,
  parameter int ADDR_W    = 32,
  parameter int OUT_W     = 32,
  parameter int SIGN_EXT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              oe,
  input  logic              W_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [OUT_W-1:0]  W_data,
  output logic [OUT_W-1:0]  R_data,
  output logic              r_valid,
  output logic              err_oor,
  input  logic              err_clr
);

  localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [SEL_W-1:0]   sel;
  logic [BANK_AW-1:0] off;
  logic               oor;
  logic               acc;
  logic               rd_req;

  assign sel    = addr[BANK_AW+SEL_W-1:BANK_AW];
  assign off    = addr[BANK_AW-1:0];
  assign oor    = (int'(sel) >= NUM_BANKS);
  // Accesses during reset are dropped entirely: no write, no read result.
  assign acc    = cs & ~rst;
  assign rd_req = acc & W_req;

  // Address bits above the bank select and unstored write-data bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{addr[ADDR_W-1:BANK_AW+SEL_W], W_data[OUT_W-1:DATA_W]};

  logic [DATA_W-1:0] bank_q [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [2**BANK_AW];
    logic [DATA_W-1:0] q;
    logic              en;

    // Only the addressed in-range bank is enabled; an OOR access touches nothing.
    assign en = acc & ~oor & (sel == SEL_W'(b));

    always_ff @(posedge clk) begin
      if (en) begin
        if (!W_req) begin
          mem[off] <= W_data[DATA_W-1:0];
        end else begin
          q <= mem[off];
        end
      end
    end

    assign bank_q[b] = q;
  end

  logic [SEL_W-1:0] sel_q;
  logic             oor_q;
  logic             rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      sel_q   <= '0;
      oor_q   <= 1'b0;
      err_oor <= 1'b0;
    end else begin
      rd_q <= rd_req;
      if (rd_req) begin
        sel_q <= sel;
        oor_q <= oor;
      end
      // Set has priority over clear so a concurrent error is never lost.
      if (cs && oor) begin
        err_oor <= 1'b1;
      end else if (err_clr) begin
        err_oor <= 1'b0;
      end
    end
  end

  logic [DATA_W-1:0] word;
  logic [OUT_W-1:0]  ext;
  logic [OUT_W-1:0]  rd_data;

  always_comb begin
    word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sel_q == SEL_W'(b)) begin
        word = bank_q[b];
      end
    end
  end

  always_comb begin
    ext = '0;
    if (SIGN_EXT != 0) begin
      ext = OUT_W'($signed(word));
    end else begin
      ext = OUT_W'(word);
    end
  end

  // Zero-fill for unmapped reads, disabled output and non-read cycles.
  assign rd_data = (rd_q && !oor_q && oe) ? ext : '0;

`ifdef SRAM_OUTREG_EN
  logic [OUT_W-1:0] out_data;
  logic             out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_data  <= rd_data;
      out_valid <= rd_q;
    end
  end

  assign R_data  = out_data;
  assign r_valid = out_valid;
`else
  assign R_data  = rd_data;
  assign r_valid = rd_q;
`endif

endmodule

// File: tb/tb_banked_sram_buffer.sv
// tb/tb_banked_sram_buffer.sv - scoreboard bench for banked_sram_buffer (sign- and zero-extending instances)

module tb_banked_sram_buffer;

`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        oe = 1'b1;
  logic        W_req = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] W_data = '0;
  logic        err_clr = 1'b0;

  logic [31:0] R_data, R_data_z;
  logic        r_valid, r_valid_z;
  logic        err_oor, err_oor_z;

  banked_sram_buffer #(.SIGN_EXT(1)) dut_s (
    .clk(clk), .rst(rst), .cs(cs), .oe(oe), .W_req(W_req), .addr(addr),
    .W_data(W_data), .R_data(R_data), .r_valid(r_valid), .err_oor(err_oor),
    .err_clr(err_clr)
  );

  banked_sram_buffer #(.SIGN_EXT(0)) dut_z (
    .clk(clk), .rst(rst), .cs(cs), .oe(oe), .W_req(W_req), .addr(addr),
    .W_data(W_data), .R_data(R_data_z), .r_valid(r_valid_z), .err_oor(err_oor_z),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] ds;
    logic [31:0] dz;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_m[int];
  int          written[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic err_m = 1'b0;
  logic err_nxt = 1'b0;
  logic pend = 1'b0;
  logic pend_inr = 1'b0;
  logic [15:0] pend_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // One clock cycle of stimulus; o is the oe value for this cycle (data cycle of the previous read).
  task automatic step(input logic c, input logic wn, input logic [31:0] a, input logic [31:0] wd,
                      input logic o, input logic clr, input logic r);
    exp_t e;
    int   bank;
    int   key;
    @(posedge clk);
    #1;
    cyc++;
    err_m = err_nxt;
    if (pend) begin
      e.due = cyc + LAT - 1;
      e.ds  = (o && pend_inr) ? {{16{pend_word[15]}}, pend_word} : 32'h0;
      e.dz  = (o && pend_inr) ? {16'h0, pend_word} : 32'h0;
      exp_q.push_back(e);
    end
    cs = c; W_req = wn; addr = a; W_data = wd; oe = o; err_clr = clr; rst = r;
    bank = int'(a[17:15]);
    key  = int'(a[17:0]);
    pend = c && wn && !r;
    pend_inr = (bank < 6);
    pend_word = (pend && pend_inr && mem_m.exists(key)) ? mem_m[key] : 16'h0;
    if (c && !wn && !r && bank < 6) begin
      if (!mem_m.exists(key)) written.push_back(key);
      mem_m[key] = wd[15:0];
    end
    if (r) err_nxt = 1'b0;
    else if (c && bank >= 6) err_nxt = 1'b1;
    else if (clr) err_nxt = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: checks every cycle in the middle of the clock period.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      logic ev;
      exp_t e;
      chk("err_oor_s", {31'h0, err_oor}, {31'h0, err_m});
      chk("err_oor_z", {31'h0, err_oor_z}, {31'h0, err_m});
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("r_valid_s", {31'h0, r_valid}, {31'h0, ev});
      chk("r_valid_z", {31'h0, r_valid_z}, {31'h0, ev});
      if (ev) begin
        e = exp_q.pop_front();
        chk("R_data_s", R_data, e.ds);
        chk("R_data_z", R_data_z, e.dz);
      end else begin
        chk("R_data_idle_s", R_data, 32'h0);
        chk("R_data_idle_z", R_data_z, 32'h0);
      end
    end
  end

  int offs[6] = '{0, 1, 5, 32'h7FFE, 32'h7FFF, 3};

  initial begin
    logic [31:0] a;
    int k;
    logic oorp;
    // reset
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();
    // sign/zero extension
    step(1'b1, 1'b0, 32'h5, 32'h8001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    // bank boundary, back-to-back reads
    step(1'b1, 1'b0, 32'h7FFF, 32'h1234, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h8000, 32'h5678, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h7FFF, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h8000, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    // OOR write must not alias into bank 0; OOR read returns 0
    step(1'b1, 1'b0, 32'h0, 32'h0BEE, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h30000, 32'hAAAA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h30000, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    // clear vs. new OOR access, then plain clear
    step(1'b1, 1'b1, 32'h30000, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    // read and write issued during reset
    step(1'b1, 1'b1, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();
    step(1'b1, 1'b0, 32'h5, 32'hDEAD, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    // oe low in the data cycle
    step(1'b1, 1'b1, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k    = $urandom_range(0, 7);
      oorp = ($urandom_range(0, 7) == 0);
      a    = $urandom;
      a[17:15] = oorp ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      a[14:0]  = 15'(offs[$urandom_range(0, 5)]);
      if (k >= 5 && !oorp) begin
        if (written.size() == 0) k = 2;
        else a[17:0] = 18'(written[$urandom_range(0, written.size() - 1)]);
      end
      step(k >= 2, k < 2 ? 1'($urandom) : (k >= 5), a, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'b0);
    end
    for (int i = 0; i < LAT + 2; i++) idle();
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
